// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencing FSM with a shared memory port and a sticky memory timeout.
// Define MC_ILLEGAL_TRAP_EN to park unsupported opcodes in TRAP instead of treating them as NOPs.
module multicycle_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       bus_err,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [7:0] TO = 8'(TIMEOUT_CYCLES);

  state_t     state, nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       waiting;

  logic is_lw, is_sw, is_r, is_i, is_jal, is_beq, op_bad;

  assign is_lw  = (Op == OP_LW);
  assign is_sw  = (Op == OP_SW);
  assign is_r   = (Op == OP_R);
  assign is_i   = (Op == OP_I);
  assign is_jal = (Op == OP_JAL);
  assign is_beq = (Op == OP_BEQ);
  assign op_bad = ~(is_lw | is_sw | is_r | is_i | is_jal | is_beq);

  always_comb begin
    nxt = state;
    unique case (state)
      S_FETCH:    if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_lw, is_sw: nxt = S_MEMADR;
          is_r:         nxt = S_EXECR;
          is_i:         nxt = S_EXECI;
          is_jal:       nxt = S_JAL;
          is_beq:       nxt = S_BEQ;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            nxt = S_TRAP;
`else
            nxt = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR:   nxt = is_sw ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) nxt = S_MEMWB;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: if (mem_ready) nxt = S_FETCH;
      S_EXECR:    nxt = S_ALUWB;
      S_EXECI:    nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_JAL:      nxt = S_ALUWB;
      S_BEQ:      nxt = S_FETCH;
      S_TRAP: begin
`ifdef MC_ILLEGAL_TRAP_EN
        nxt = S_TRAP;
`else
        nxt = S_FETCH;
`endif
      end
      default:    nxt = S_FETCH;
    endcase
  end

  // A stalled wait state never changes state, so this also covers "clear on state change".
  assign waiting = ~mem_ready &
                   ((state == S_FETCH) |
                    (state == S_MEMREAD) |
                    (state == S_MEMWRITE));

  always_comb begin
    cnt_nxt = 8'd0;
    if (waiting) cnt_nxt = (cnt >= TO) ? TO : cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      cnt     <= 8'd0;
      bus_err <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      if (waiting && cnt_nxt == TO) bus_err <= 1'b1;
    end
  end

  logic [2:0] alu_f;

  always_comb begin
    alu_f = ALU_ADD;
    unique case (funct3)
      3'b000:  alu_f = (Op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_f = ALU_SLT;
      3'b110:  alu_f = ALU_OR;
      3'b111:  alu_f = ALU_AND;
      default: alu_f = ALU_ADD;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    unique case (1'b1)
      is_sw:   ImmSrc = 2'b01;
      is_beq:  ImmSrc = 2'b10;
      is_jal:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  logic pcw, mrd, mwr, irw, rw, done;

  always_comb begin
    pcw        = 1'b0;
    mrd        = 1'b0;
    mwr        = 1'b0;
    irw        = 1'b0;
    rw         = 1'b0;
    done       = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    unique case (state)
      S_FETCH: begin
        mrd       = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irw       = mem_ready;
        pcw       = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
`ifndef MC_ILLEGAL_TRAP_EN
        done    = op_bad;
`endif
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        mrd    = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw        = 1'b1;
        done      = 1'b1;
      end
      S_MEMWRITE: begin
        mwr    = 1'b1;
        AdrSrc = 1'b1;
        done   = mem_ready;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_f;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_f;
      end
      S_ALUWB: begin
        rw   = 1'b1;
        done = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pcw     = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        pcw        = Zero;
        done       = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes drop the moment rst rises, before the state register is even sampled.
  assign PCWrite    = pcw  & ~rst;
  assign MemRead    = mrd  & ~rst;
  assign MemWrite   = mwr  & ~rst;
  assign IRWrite    = irw  & ~rst;
  assign RegWrite   = rw   & ~rst;
  assign instr_done = done & ~rst;
  assign state_o    = state;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Sequencing controller for the multi-cycle RV32I datapath, with one shared memory port for instruction and data. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback. It drives the datapath mux selects, write strobes and ALU operation, and stalls on a memory ready handshake. It sits beside the register file, ALU and unified memory interface.

Parameters:
TIMEOUT_CYCLES, 16, consecutive memory-wait cycles before bus_err sets (range 2..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
Op  input  7  instruction opcode
funct3  input  3  instruction funct3
funct7b5  input  1  instruction bit 30
Zero  input  1  ALU zero flag
mem_ready  input  1  memory access completes this cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  instruction/oldPC register enable
RegWrite  output  1  register file write enable
ResultSrc  output  2  result mux select: 00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  output  2  ALU A select: 00 PC, 01 oldPC, 10 rs1
ALUSrcB  output  2  ALU B select: 00 rs2, 01 imm, 10 const 4
ImmSrc  output  2  immediate type: 00 I, 01 S, 10 B, 11 J
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
instr_done  output  1  one-cycle pulse on the last cycle of each instruction
bus_err  output  1  sticky memory timeout flag
state_o  output  4  current state encoding, debug only

Behaviour:
- Reset and asynchronous reset:
  - rst high: state = FETCH (0), wait counter = 0, bus_err = 0.
  - While rst is high, PCWrite, IRWrite, RegWrite, MemRead, MemWrite and instr_done are forced 0.
  - Reset mid-instruction abandons the instruction. No strobe fires.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10, TRAP 11.
- Transitions:
  - FETCH goes to DECODE only when mem_ready = 1; otherwise it holds.
  - DECODE by Op:
    - 0000011 (lw) or 0100011 (sw) goes to MEMADR.
    - 0110011 goes to EXECUTER.
    - 0010011 goes to EXECUTEI.
    - 1101111 goes to JAL.
    - 1100011 goes to BEQ.
    - Any other Op is handled per the Optional Feature section.
  - MEMADR goes to MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD holds until mem_ready, then goes to MEMWB.
  - MEMWRITE holds until mem_ready, then goes to FETCH.
  - MEMWB goes to FETCH.
  - EXECUTER and EXECUTEI go to ALUWB; ALUWB goes to FETCH.
  - JAL goes to ALUWB.
  - BEQ goes to FETCH.
- Outputs per state (unlisted outputs are 0):
  - FETCH: MemRead = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALU op add, ResultSrc = 10. IRWrite and PCWrite equal mem_ready.
  - DECODE: ALUSrcA = 01, ALUSrcB = 01, add (branch/jump target into ALUOut).
  - MEMADR: ALUSrcA = 10, ALUSrcB = 01, add.
  - MEMREAD: MemRead = 1, AdrSrc = 1.
  - MEMWB: ResultSrc = 01, RegWrite = 1.
  - MEMWRITE: MemWrite = 1, AdrSrc = 1.
  - EXECUTER: ALUSrcA = 10, ALUSrcB = 00, ALU op from funct fields.
  - EXECUTEI: ALUSrcA = 10, ALUSrcB = 01, ALU op from funct fields.
  - ALUWB: ResultSrc = 00, RegWrite = 1.
  - JAL: ALUSrcA = 01, ALUSrcB = 10, add, ResultSrc = 00, PCWrite = 1.
  - BEQ: ALUSrcA = 10, ALUSrcB = 00, sub, ResultSrc = 00, PCWrite = Zero.
- ImmSrc: combinational from Op in every state. lw and I-type give 00, sw 01, beq 10, jal 11, others 00.
- ALU op from funct fields:
  - funct3 000: sub when Op[5] = 1 and funct7b5 = 1, else add.
  - funct3 010: slt. funct3 110: or. funct3 111: and.
  - Other funct3: add.
- instr_done = 1 in MEMWB, MEMWRITE with mem_ready, ALUWB and BEQ.
- Wait counter:
  - Increments each cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready = 0.
  - Clears on mem_ready or any state change.
  - Saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES, bus_err sets and holds until rst. The FSM keeps waiting.
  - mem_ready in the same cycle the counter would reach the limit means no error.

Optional Feature:
MC_ILLEGAL_TRAP_EN.
- Defined: an unsupported Op in DECODE goes to TRAP.
  - TRAP holds until rst, all strobes 0, state_o = 11, instr_done never pulses.
- Undefined: an unsupported Op in DECODE goes to FETCH with instr_done = 1 (executes as NOP, PC already advanced). TRAP is unreachable.

Test Plan:
- lw, mem_ready held 0 for 3 FETCH cycles and 2 MEMREAD cycles -> state sequence 0,0,0,0,1,2,3,3,3,4,0. RegWrite high only in state 4. IRWrite high only on the 4th cycle.
- add then sub (Op 0110011, funct3 000, funct7b5 0 then 1), mem_ready = 1 -> ALUControl 000 then 001 in state 6. Each instruction takes 4 cycles with instr_done in ALUWB.
- beq with Zero = 1, then Zero = 0 -> PCWrite = 1 in state 10 for the first, 0 for the second. Both return to state 0 next cycle.
- TIMEOUT_CYCLES = 4, mem_ready stuck 0 in MEMWRITE -> bus_err rises on the 4th wait cycle and stays high. mem_ready then gives MemWrite completion and state 0.
- Op 1111111 -> with MC_ILLEGAL_TRAP_EN: state 11 persists 10 cycles with zero strobes. Without it: returns to state 0 after DECODE.
- rst asserted mid-MEMREAD -> state_o = 0 immediately, all strobes 0, bus_err = 0. After release, fetch resumes.
